// File: rtl/mac35_parallel_pipe_param.sv
// Pipelined A_W x B_W multiplier built from four sliced partial products,
// feeding a wide accumulator with per-sample signed/unsigned mode and a sticky overflow flag.
module mac35_parallel_pipe_param #(
    parameter int A_W   = 35,
    parameter int B_W   = 35,
    parameter int SPLIT = 17,
    parameter int ACC_W = 80
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    input  logic               SIGNED_MODE,
    input  logic [A_W-1:0]     A_IN,
    input  logic [B_W-1:0]     B_IN,
    input  logic               ACC_EN,
    input  logic               ACC_CLR,
    output logic [A_W+B_W-1:0] PROD_OUT,
    output logic               PROD_VALID,
    output logic [ACC_W-1:0]   ACCUM_OUT,
    output logic               ACCUM_VALID,
    output logic               ACC_OVF
);
    localparam int PW  = A_W + B_W;
    localparam int AHW = A_W - SPLIT;
    localparam int BHW = B_W - SPLIT;
    localparam int LLW = 2 * SPLIT + 2;
    localparam int LHW = SPLIT + BHW + 2;
    localparam int HLW = AHW + SPLIT + 2;
    localparam int HHW = AHW + BHW + 2;

    localparam int C_SGN = 2;
    localparam int C_EN  = 1;
    localparam int C_CLR = 0;

    // Valid and {signed, acc_en, acc_clr} travel alongside the data, one entry per stage.
    logic       valid_reg [1:4];
    logic [2:0] ctrl_reg  [1:4];

    logic [A_W-1:0] s1_a_reg;
    logic [B_W-1:0] s1_b_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 1; i <= 4; i++) begin
                valid_reg[i] <= 1'b0;
            end
        end else begin
            valid_reg[1] <= IN_VALID;
            for (int i = 2; i <= 4; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
        end
        if (IN_VALID) begin
            s1_a_reg    <= A_IN;
            s1_b_reg    <= B_IN;
            ctrl_reg[1] <= {SIGNED_MODE, ACC_EN, ACC_CLR};
        end
        for (int i = 2; i <= 4; i++) begin
            if (valid_reg[i-1]) begin
                ctrl_reg[i] <= ctrl_reg[i-1];
            end
        end
    end

    // Stage 2: low slices are always unsigned; high slices take the sample's mode.
    logic              s1_sgn;
    logic signed [SPLIT:0] al_s, bl_s;
    logic signed [AHW:0]   ah_s;
    logic signed [BHW:0]   bh_s;

    assign s1_sgn = ctrl_reg[1][C_SGN];
    assign al_s   = {1'b0, s1_a_reg[SPLIT-1:0]};
    assign bl_s   = {1'b0, s1_b_reg[SPLIT-1:0]};
    assign ah_s   = {s1_sgn & s1_a_reg[A_W-1], s1_a_reg[A_W-1:SPLIT]};
    assign bh_s   = {s1_sgn & s1_b_reg[B_W-1], s1_b_reg[B_W-1:SPLIT]};

    logic signed [LLW-1:0] pp_ll_reg;
    logic signed [LHW-1:0] pp_lh_reg;
    logic signed [HLW-1:0] pp_hl_reg;
    logic signed [HHW-1:0] pp_hh_reg;

    always_ff @(posedge CLK) begin
        if (valid_reg[1]) begin
            pp_ll_reg <= LLW'(al_s) * LLW'(bl_s);
            pp_lh_reg <= LHW'(al_s) * LHW'(bh_s);
            pp_hl_reg <= HLW'(ah_s) * HLW'(bl_s);
            pp_hh_reg <= HHW'(ah_s) * HHW'(bh_s);
        end
    end

    // Stage 3: two balanced adds (cross terms, low+high terms); stage 4 merges them.
    logic [PW-1:0] ll_ext, lh_ext, hl_ext, hh_ext;
    logic [PW-1:0] cross_reg, lowhigh_reg;

    assign ll_ext = PW'(pp_ll_reg);
    assign lh_ext = PW'(pp_lh_reg);
    assign hl_ext = PW'(pp_hl_reg);
    assign hh_ext = PW'(pp_hh_reg);

    always_ff @(posedge CLK) begin
        if (valid_reg[2]) begin
            cross_reg   <= lh_ext + hl_ext;
            lowhigh_reg <= ll_ext + (hh_ext << (2 * SPLIT));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PROD_OUT <= '0;
        end else if (valid_reg[3]) begin
            PROD_OUT <= lowhigh_reg + (cross_reg << SPLIT);
        end
    end

    assign PROD_VALID = valid_reg[4];

    // Accumulate stage: extension and overflow rule follow the sample's own mode.
    logic               s4_sgn, s4_en, s4_clr;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     acc_sum;
    logic               ovf_signed, ovf_unsigned, ovf_hit;

    assign s4_sgn       = ctrl_reg[4][C_SGN];
    assign s4_en        = ctrl_reg[4][C_EN];
    assign s4_clr       = ctrl_reg[4][C_CLR];
    assign prod_ext     = s4_sgn ? ACC_W'($signed(PROD_OUT)) : ACC_W'(PROD_OUT);
    assign acc_sum      = {1'b0, ACCUM_OUT} + {1'b0, prod_ext};
    assign ovf_signed   = (ACCUM_OUT[ACC_W-1] == prod_ext[ACC_W-1]) &&
                          (acc_sum[ACC_W-1] != ACCUM_OUT[ACC_W-1]);
    assign ovf_unsigned = acc_sum[ACC_W];
    assign ovf_hit      = s4_sgn ? ovf_signed : ovf_unsigned;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ACCUM_OUT   <= '0;
            ACCUM_VALID <= 1'b0;
            ACC_OVF     <= 1'b0;
        end else begin
            ACCUM_VALID <= valid_reg[4] & s4_en;
            if (valid_reg[4] && s4_en) begin
                if (s4_clr) begin
                    ACCUM_OUT <= prod_ext;
                    ACC_OVF   <= 1'b0;
                end else begin
                    ACCUM_OUT <= acc_sum[ACC_W-1:0];
                    ACC_OVF   <= ACC_OVF | ovf_hit;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac35_parallel_pipe_param.sv
// Scoreboard bench: two DUTs (ACC_W=80 and ACC_W=72) share stimulus; a reference
// model computes products and accumulator values with plain wide arithmetic.
module tb_mac35_parallel_pipe_param;
    localparam int A_W = 35;
    localparam int B_W = 35;
    localparam int PW  = 70;

    logic           CLK = 1'b0;
    logic           RST, IN_VALID, SIGNED_MODE, ACC_EN, ACC_CLR;
    logic [A_W-1:0] A_IN;
    logic [B_W-1:0] B_IN;

    logic [PW-1:0] prod_a, prod_b;
    logic          pv_a, pv_b, av_a, av_b, ovf_a, ovf_b;
    logic [79:0]   acc_a;
    logic [71:0]   acc_b;

    mac35_parallel_pipe_param dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .SIGNED_MODE(SIGNED_MODE),
        .A_IN(A_IN), .B_IN(B_IN), .ACC_EN(ACC_EN), .ACC_CLR(ACC_CLR),
        .PROD_OUT(prod_a), .PROD_VALID(pv_a), .ACCUM_OUT(acc_a),
        .ACCUM_VALID(av_a), .ACC_OVF(ovf_a)
    );

    mac35_parallel_pipe_param #(.ACC_W(72)) dut72 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .SIGNED_MODE(SIGNED_MODE),
        .A_IN(A_IN), .B_IN(B_IN), .ACC_EN(ACC_EN), .ACC_CLR(ACC_CLR),
        .PROD_OUT(prod_b), .PROD_VALID(pv_b), .ACCUM_OUT(acc_b),
        .ACCUM_VALID(av_b), .ACC_OVF(ovf_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [PW-1:0] prod;
        int            cyc;
    } prod_t;

    typedef struct {
        logic [127:0] acc80;
        logic [127:0] acc72;
        bit           ovf80;
        bit           ovf72;
        int           cyc;
    } acc_t;

    prod_t prod_q[$];
    acc_t  acc_q[$];

    int           cycle = 0;
    int           checks = 0;
    int           errors = 0;
    bit           record = 1'b1;
    logic [127:0] m_acc80, m_acc72;
    bit           m_ovf80, m_ovf72;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Exact product of the operands as integers in the chosen mode, kept modulo 2^70.
    function automatic logic [PW-1:0] ref_prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                               input bit sgn);
        logic signed [PW-1:0] x, y;
        x = sgn ? {{35{a[A_W-1]}}, a} : {35'd0, a};
        y = sgn ? {{35{b[B_W-1]}}, b} : {35'd0, b};
        return x * y;
    endfunction

    // Accumulator step of width w: overflow is "true sum leaves the representable range".
    task automatic acc_step(input int w, input logic [127:0] acc_in, input bit ovf_in,
                            input logic [PW-1:0] p, input bit sgn, input bit clr,
                            output logic [127:0] acc_out, output bit ovf_out);
        logic [127:0]        mask, ext, utot;
        logic signed [127:0] av, tot, lim;
        mask = (128'd1 << w) - 128'd1;
        ext  = sgn ? {{58{p[PW-1]}}, p} : {58'd0, p};
        if (clr) begin
            acc_out = ext & mask;
            ovf_out = 1'b0;
        end else if (sgn) begin
            av      = acc_in[w-1] ? (acc_in | ~mask) : acc_in;
            tot     = av + ext;
            lim     = 128'sd1 <<< (w - 1);
            ovf_out = ovf_in | (tot >= lim) | (tot < -lim);
            acc_out = tot & mask;
        end else begin
            utot    = acc_in + ext;
            ovf_out = ovf_in | ((utot >> w) != 128'd0);
            acc_out = utot & mask;
        end
    endtask

    task automatic issue(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                         input bit sgn, input bit en, input bit clr);
        logic [PW-1:0] p;
        acc_t          e;
        A_IN = a; B_IN = b; SIGNED_MODE = sgn; ACC_EN = en; ACC_CLR = clr; IN_VALID = 1'b1;
        if (record) begin
            p = ref_prod(a, b, sgn);
            prod_q.push_back('{p, cycle + 4});
            if (en) begin
                acc_step(80, m_acc80, m_ovf80, p, sgn, clr, m_acc80, m_ovf80);
                acc_step(72, m_acc72, m_ovf72, p, sgn, clr, m_acc72, m_ovf72);
                e.acc80 = m_acc80; e.acc72 = m_acc72;
                e.ovf80 = m_ovf80; e.ovf72 = m_ovf72; e.cyc = cycle + 5;
                acc_q.push_back(e);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) begin
            IN_VALID = 1'b0;
            A_IN = A_W'($urandom); B_IN = B_W'($urandom);
            ACC_EN = 1'($urandom); ACC_CLR = 1'($urandom);
            @(posedge CLK); #1;
        end
    endtask

    function automatic logic [A_W-1:0] rnd_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       r = 64'd0;
            1:       r = 64'h7_FFFF_FFFF;
            2:       r = 64'h4_0000_0000;
            3:       r = 64'h3_FFFF_FFFF;
            default: ;
        endcase
        return r[A_W-1:0];
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_prod80"},  128'(prod_a), 128'd0);
        check({tag, "_pv80"},    128'(pv_a),   128'd0);
        check({tag, "_acc80"},   128'(acc_a),  128'd0);
        check({tag, "_av80"},    128'(av_a),   128'd0);
        check({tag, "_ovf80"},   128'(ovf_a),  128'd0);
        check({tag, "_prod72"},  128'(prod_b), 128'd0);
        check({tag, "_pv72"},    128'(pv_b),   128'd0);
        check({tag, "_acc72"},   128'(acc_b),  128'd0);
        check({tag, "_av72"},    128'(av_b),   128'd0);
        check({tag, "_ovf72"},   128'(ovf_b),  128'd0);
    endtask

    // Monitor: every presented output must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (pv_a || pv_b) begin
            if (prod_q.size() == 0) begin
                check("prod_unexpected", 128'({pv_a, pv_b}), 128'd0);
            end else begin
                prod_t e;
                e = prod_q.pop_front();
                check("prod_valid80", 128'(pv_a), 128'd1);
                check("prod_valid72", 128'(pv_b), 128'd1);
                check("prod80", 128'(prod_a), 128'(e.prod));
                check("prod72", 128'(prod_b), 128'(e.prod));
                check("prod_latency", 128'(cycle), 128'(e.cyc));
                $display("prod  cyc=%0d prod=0x%0h", cycle, prod_a);
            end
        end
        if (av_a || av_b) begin
            if (acc_q.size() == 0) begin
                check("acc_unexpected", 128'({av_a, av_b}), 128'd0);
            end else begin
                acc_t e;
                e = acc_q.pop_front();
                check("acc_valid80", 128'(av_a), 128'd1);
                check("acc_valid72", 128'(av_b), 128'd1);
                check("acc80", 128'(acc_a), e.acc80);
                check("acc72", 128'(acc_b), e.acc72);
                check("ovf80", 128'(ovf_a), 128'(e.ovf80));
                check("ovf72", 128'(ovf_b), 128'(e.ovf72));
                check("acc_latency", 128'(cycle), 128'(e.cyc));
                $display("accum cyc=%0d acc80=0x%0h acc72=0x%0h ovf=%0b/%0b",
                         cycle, acc_a, acc_b, ovf_a, ovf_b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        m_acc80 = '0; m_acc72 = '0; m_ovf80 = 1'b0; m_ovf72 = 1'b0;
        RST = 1'b1; IN_VALID = 1'b0; SIGNED_MODE = 1'b0; ACC_EN = 1'b0; ACC_CLR = 1'b0;
        A_IN = '0; B_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_outputs_zero("reset");
        RST = 1'b0;
        bubbles(2);

        // Directed products: unsigned and signed views of the same operands
        issue(35'h7_FFFF_FFFF, 35'd7835, 1'b0, 1'b0, 1'b0);
        bubbles(5);
        issue(35'h7_FFFF_FFFF, 35'd7835, 1'b1, 1'b0, 1'b0);
        issue(35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        bubbles(5);

        // Back-to-back accumulation with a non-accumulated sample mid-stream
        issue(35'd3, 35'd4, 1'b0, 1'b1, 1'b1);
        issue(35'd5, 35'd6, 1'b0, 1'b1, 1'b0);
        issue(35'd7, 35'd8, 1'b0, 1'b1, 1'b0);
        issue(35'd9, 35'd9, 1'b0, 1'b0, 1'b0);
        issue(35'd1, 35'd1, 1'b0, 1'b1, 1'b0);
        bubbles(6);

        // Signed overflow: (-2^34)^2 = 2^68 repeatedly; 72-bit accumulator overflows on the 8th
        issue(35'h4_0000_0000, 35'h4_0000_0000, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            issue(35'h4_0000_0000, 35'h4_0000_0000, 1'b1, 1'b1, 1'b0);
        end
        issue(35'd2, 35'd3, 1'b0, 1'b0, 1'b0);
        issue(35'd1, 35'd1, 1'b0, 1'b1, 1'b0);
        issue(35'd2, 35'd2, 1'b1, 1'b1, 1'b1);
        issue(35'h7_FFFF_FFFF, 35'd1, 1'b1, 1'b1, 1'b0);
        bubbles(6);

        // Randomized mixed-mode traffic with bubbles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                bubbles(1);
            end else begin
                issue(rnd_op(), rnd_op(), 1'($urandom), ($urandom_range(0, 9) < 7),
                      ($urandom_range(0, 9) == 0));
            end
        end
        bubbles(8);

        // Reset with two samples in flight: they must vanish
        record = 1'b0;
        issue(35'd11, 35'd13, 1'b0, 1'b1, 1'b0);
        issue(35'd17, 35'd19, 1'b1, 1'b1, 1'b0);
        RST = 1'b1;
        issue(35'd23, 35'd29, 1'b0, 1'b1, 1'b0);
        check_outputs_zero("midreset");
        RST = 1'b0;
        record = 1'b1;
        m_acc80 = '0; m_acc72 = '0; m_ovf80 = 1'b0; m_ovf72 = 1'b0;
        issue(35'd6, 35'd7, 1'b0, 1'b1, 1'b0);
        issue(35'h7_FFFF_FFFE, 35'd3, 1'b1, 1'b1, 1'b0);
        bubbles(10);

        check("prod_queue_drained", 128'(prod_q.size()), 128'd0);
        check("acc_queue_drained",  128'(acc_q.size()),  128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
